// File: rtl/rv32i_fetch_decode_if.sv
// Fetch/decode bus bundle: the instruction-memory port, the control word
// with its valid/ready handshake, the datapath completion/redirect
// return path, and the status outputs.
interface rv32i_fetch_decode_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [3:0]  instType;
  logic [2:0]  fun3;
  logic        fun7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] pc;
  logic [31:0] imm;

  logic        dp_done;
  logic        dp_redirect;
  logic [31:0] dp_target;

  logic        illegal;
  logic [31:0] instret;

  // Sequencer side: drives the fetch request, the control word and the status.
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output ctrl_valid, instType, fun3, fun7, rd, rs1, rs2, pc, imm,
    input  ctrl_ready,
    input  dp_done, dp_redirect, dp_target,
    output illegal, instret
  );

  // Memory/datapath side: answers fetches, accepts control words, retires them.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  ctrl_valid, instType, fun3, fun7, rd, rs1, rs2, pc, imm,
    output ctrl_ready,
    output dp_done, dp_redirect, dp_target,
    input  illegal, instret
  );
endinterface

// File: rtl/rv32i_fetch_decode.sv
// Multicycle RV32I fetch/decode sequencer. Fetches one instruction at a
// time, decodes it into a control word, hands it to the datapath and waits
// for completion (and an optional redirect) before fetching the next one.
// Owns the architectural PC and the retired-instruction counter. Illegal
// opcodes and misaligned redirect targets park the block in a terminal trap
// state until reset.
module rv32i_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32i_fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    ISSUE   = 3'd2,
    EXECUTE = 3'd3,
    TRAP    = 3'd4
  } state_t;

  localparam logic [3:0] T_LOAD    = 4'd0;
  localparam logic [3:0] T_IMM     = 4'd1;
  localparam logic [3:0] T_STORE   = 4'd2;
  localparam logic [3:0] T_REG     = 4'd3;
  localparam logic [3:0] T_LUI     = 4'd4;
  localparam logic [3:0] T_AUIPC   = 4'd5;
  localparam logic [3:0] T_BRNCH   = 4'd6;
  localparam logic [3:0] T_JALR    = 4'd7;
  localparam logic [3:0] T_JAL     = 4'd8;
  localparam logic [3:0] T_INVALID = 4'd15;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        imem_req_q;
  logic        ctrl_valid_q;
  logic        illegal_q;
  logic [31:0] instret_q;
  logic [3:0]  type_q;
  logic [2:0]  fun3_q;
  logic        fun7_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] pc_out_q;
  logic [31:0] imm_q;

  logic [3:0]  d_type;
  logic [2:0]  d_fun3;
  logic        d_fun7;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [31:0] d_imm;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  // The fetch address is always the architectural PC.
  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.instType   = type_q;
  assign bus.fun3       = fun3_q;
  assign bus.fun7       = fun7_q;
  assign bus.rd         = rd_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.pc         = pc_out_q;
  assign bus.imm        = imm_q;
  assign bus.illegal    = illegal_q;
  assign bus.instret    = instret_q;

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  // Decode the latched instruction word into a control word, zeroing the
  // fields each instruction format does not use.
  always_comb begin
    d_type = T_INVALID;
    d_fun3 = instr_q[14:12];
    d_fun7 = 1'b0;
    d_rd   = instr_q[11:7];
    d_rs1  = instr_q[19:15];
    d_rs2  = instr_q[24:20];
    d_imm  = 32'h0;

    case (instr_q[6:0])
      7'b0000011: d_type = T_LOAD;
      7'b0010011: d_type = T_IMM;
      7'b0100011: d_type = T_STORE;
      7'b0110011: d_type = T_REG;
      7'b0110111: d_type = T_LUI;
      7'b0010111: d_type = T_AUIPC;
      7'b1100011: d_type = T_BRNCH;
      7'b1100111: d_type = T_JALR;
      7'b1101111: d_type = T_JAL;
      default:    d_type = T_INVALID;
    endcase
    if (instr_q[1:0] != 2'b11) begin
      d_type = T_INVALID;
    end

    case (d_type)
      T_LOAD, T_IMM, T_JALR: d_imm = imm_i;
      T_STORE:               d_imm = imm_s;
      T_BRNCH:               d_imm = imm_b;
      T_LUI, T_AUIPC:        d_imm = imm_u;
      T_JAL:                 d_imm = imm_j;
      default:               d_imm = 32'h0;
    endcase

    if (d_type == T_STORE || d_type == T_BRNCH) begin
      d_rd = 5'd0;
    end
    if (d_type == T_LUI || d_type == T_AUIPC || d_type == T_JAL) begin
      d_rs1  = 5'd0;
      d_fun3 = 3'd0;
    end
    if (!(d_type == T_STORE || d_type == T_BRNCH || d_type == T_REG)) begin
      d_rs2 = 5'd0;
    end
    if (d_type == T_REG || (d_type == T_IMM && instr_q[14:12] == 3'b101)) begin
      d_fun7 = instr_q[30];
    end
  end

  // Sequencer: fetch, decode, issue, wait for completion; all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      imem_req_q   <= 1'b0;
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      instret_q    <= 32'h0;
      type_q       <= T_INVALID;
      fun3_q       <= 3'd0;
      fun7_q       <= 1'b0;
      rd_q         <= 5'd0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      pc_out_q     <= 32'h0;
      imm_q        <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (bus.imem_ack) begin
            instr_q    <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state      <= DECODE;
          end
        end

        DECODE: begin
          type_q <= d_type;
          if (d_type == T_INVALID) begin
            illegal_q <= 1'b1;
            state     <= TRAP;
          end else begin
            fun3_q       <= d_fun3;
            fun7_q       <= d_fun7;
            rd_q         <= d_rd;
            rs1_q        <= d_rs1;
            rs2_q        <= d_rs2;
            imm_q        <= d_imm;
            pc_out_q     <= pc_q;
            ctrl_valid_q <= 1'b1;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.ctrl_ready) begin
            ctrl_valid_q <= 1'b0;
            state        <= EXECUTE;
          end
        end

        EXECUTE: begin
          if (bus.dp_done) begin
            if (bus.dp_redirect && bus.dp_target[1:0] != 2'b00) begin
              illegal_q <= 1'b1;
              state     <= TRAP;
            end else begin
              pc_q       <= bus.dp_redirect ? bus.dp_target : pc_q + 32'd4;
              instret_q  <= instret_q + 32'd1;
              imem_req_q <= 1'b1;
              state      <= FETCH;
            end
          end
        end

        TRAP: begin
          imem_req_q   <= 1'b0;
          ctrl_valid_q <= 1'b0;
          illegal_q    <= 1'b1;
        end

        default: begin
          state <= TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_decode.sv
// Directed bench for rv32i_fetch_decode. Expected control words are pushed
// to a scoreboard when an instruction is fetched and popped when ctrl_valid
// appears; a small PC/instret model tracks retirement.
module tb_rv32i_fetch_decode;

  typedef struct packed {
    logic [3:0]  t;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] imm;
  } cw_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rv32i_fetch_decode_if bus();

  rv32i_fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  cw_t         expQ[$];
  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] modelPc = 32'h0;
  logic [31:0] modelInstret = 32'h0;

  function automatic cw_t mk(input logic [3:0] t, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm);
    cw_t c;
    c.t = t; c.f3 = f3; c.f7 = f7; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2;
    c.pc = 32'h0; c.imm = imm;
    return c;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string pfx, input cw_t e);
    checkOutput({pfx, ".instType"}, 32'(bus.instType), 32'(e.t));
    checkOutput({pfx, ".fun3"},     32'(bus.fun3),     32'(e.f3));
    checkOutput({pfx, ".fun7"},     32'(bus.fun7),     32'(e.f7));
    checkOutput({pfx, ".rd"},       32'(bus.rd),       32'(e.rd));
    checkOutput({pfx, ".rs1"},      32'(bus.rs1),      32'(e.rs1));
    checkOutput({pfx, ".rs2"},      32'(bus.rs2),      32'(e.rs2));
    checkOutput({pfx, ".pc"},       bus.pc,            e.pc);
    checkOutput({pfx, ".imm"},      bus.imm,           e.imm);
  endtask

  task automatic waitReq();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("imem_req_up", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic applyReset();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("rst.imem_req",   32'(bus.imem_req),   32'd0);
    checkOutput("rst.ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
    checkOutput("rst.illegal",    32'(bus.illegal),    32'd0);
    checkOutput("rst.instret",    bus.instret,         32'd0);
    checkOutput("rst.imem_addr",  bus.imem_addr,       32'd0);
    checkWord("rst", mk(4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0));
    rst = 1'b1;
    modelPc = 32'h0;
    modelInstret = 32'h0;
    tick();
    checkOutput("rst.req_first_cycle", 32'(bus.imem_req), 32'd1);
  endtask

  // One full instruction: fetch (optionally delayed), issue (optionally
  // stalled, optionally with ack/done noise that must be ignored), complete.
  task automatic applyStimulus(input logic [31:0] rdata, input int ackDelay, input int stall,
                               input bit noise, input logic redir, input logic [31:0] tgt,
                               input cw_t e);
    cw_t         got;
    int          n;
    logic [31:0] addr0;
    waitReq();
    addr0 = bus.imem_addr;
    checkOutput("fetch_addr", addr0, modelPc);
    for (int i = 0; i < ackDelay; i++) begin
      tick();
      checkOutput("req_hold",  32'(bus.imem_req), 32'd1);
      checkOutput("addr_hold", bus.imem_addr, addr0);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = rdata;
    e.pc = modelPc;
    expQ.push_back(e);
    tick();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    checkOutput("req_drop", 32'(bus.imem_req), 32'd0);
    n = 0;
    while (bus.ctrl_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("valid_latency", 32'(n), 32'd1);
    testCount++;
    assert (expQ.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end
    if (expQ.size() > 0) got = expQ.pop_front();
    else got = e;
    checkWord("issue", got);
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        bus.dp_done = 1'b1;
        bus.dp_redirect = 1'b1;
        bus.dp_target = 32'h0000_0080;
      end
      tick();
      checkOutput("stall_valid", 32'(bus.ctrl_valid), 32'd1);
      checkWord("stall", got);
    end
    bus.ctrl_ready = 1'b1;
    tick();
    bus.ctrl_ready = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dp_done = 1'b0;
    bus.dp_redirect = 1'b0;
    bus.dp_target = 32'h0;
    checkOutput("accept_valid_low", 32'(bus.ctrl_valid), 32'd0);
    checkWord("exec", got);
    if (noise) begin
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      checkOutput("exec_noise_req", 32'(bus.imem_req), 32'd0);
      checkOutput("exec_noise_instret", bus.instret, modelInstret);
      checkWord("exec_noise", got);
    end
    bus.dp_done = 1'b1;
    bus.dp_redirect = redir;
    bus.dp_target = tgt;
    tick();
    bus.dp_done = 1'b0;
    bus.dp_redirect = 1'b0;
    bus.dp_target = 32'h0;
  endtask

  task automatic retire(input logic redir, input logic [31:0] tgt);
    modelPc = redir ? tgt : modelPc + 32'd4;
    modelInstret = modelInstret + 32'd1;
    checkOutput("next_addr",   bus.imem_addr, modelPc);
    checkOutput("instret",     bus.instret, modelInstret);
    checkOutput("req_next",    32'(bus.imem_req), 32'd1);
    checkOutput("illegal_clr", 32'(bus.illegal), 32'd0);
  endtask

  task automatic checkTrap(input logic [31:0] instretExp);
    for (int i = 0; i < 3; i++) begin
      checkOutput("trap.illegal",    32'(bus.illegal), 32'd1);
      checkOutput("trap.imem_req",   32'(bus.imem_req), 32'd0);
      checkOutput("trap.ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
      checkOutput("trap.instret",    bus.instret, instretExp);
      checkOutput("trap.imem_addr",  bus.imem_addr, modelPc);
      tick();
    end
  endtask

  task automatic fetchOnly(input logic [31:0] rdata);
    waitReq();
    checkOutput("fetch_addr", bus.imem_addr, modelPc);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = rdata;
    tick();
    bus.imem_ack = 1'b0;
    tick();
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.ctrl_ready = 1'b0;
    bus.dp_done = 1'b0;
    bus.dp_redirect = 1'b0;
    bus.dp_target = 32'h0;

    applyReset();

    // addi x1,x0,5
    applyStimulus(32'h0050_0093, 0, 0, 0, 1'b0, 32'h0, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    retire(1'b0, 32'h0);
    // sw x2,-4(x1), ready held low 3 cycles
    applyStimulus(32'hFE20_AE23, 0, 3, 0, 1'b0, 32'h0, mk(4'd2, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC));
    retire(1'b0, 32'h0);
    // lui x5,0x12345 then redirect to 0x40
    applyStimulus(32'h1234_52B7, 0, 0, 0, 1'b1, 32'h40, mk(4'd4, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000));
    retire(1'b1, 32'h40);
    // sub x3,x1,x2 with delayed ack and ack/done noise outside FETCH
    applyStimulus(32'h4020_81B3, 4, 2, 1, 1'b0, 32'h0, mk(4'd3, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0));
    retire(1'b0, 32'h0);
    // srai x4,x1,3 (fun7 carried for shift-right immediate)
    applyStimulus(32'h4030_D213, 0, 0, 0, 1'b0, 32'h0, mk(4'd1, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'h0000_0403));
    retire(1'b0, 32'h0);
    // beq x1,x2,-8, taken back to 0x40
    applyStimulus(32'hFE20_8CE3, 0, 0, 0, 1'b1, 32'h40, mk(4'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8));
    retire(1'b1, 32'h40);
    // jal x1,+16
    applyStimulus(32'h0100_00EF, 0, 0, 0, 1'b1, 32'h50, mk(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16));
    retire(1'b1, 32'h50);
    // lw x6,8(x2)
    applyStimulus(32'h0081_2303, 0, 1, 0, 1'b0, 32'h0, mk(4'd0, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, 32'd8));
    retire(1'b0, 32'h0);
    // jalr x1,-4(x5)
    applyStimulus(32'hFFC2_80E7, 0, 0, 0, 1'b1, 32'h100, mk(4'd7, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'hFFFF_FFFC));
    retire(1'b1, 32'h100);
    // auipc x7,0xFFFFF, redirected to the top word to exercise PC wrap
    applyStimulus(32'hFFFF_F397, 0, 0, 0, 1'b1, 32'hFFFF_FFFC, mk(4'd5, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'hFFFF_F000));
    retire(1'b1, 32'hFFFF_FFFC);
    // addi at 0xFFFFFFFC, PC+4 wraps to 0
    applyStimulus(32'h0050_0093, 0, 0, 0, 1'b0, 32'h0, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    retire(1'b0, 32'h0);
    checkOutput("pc_wrap", bus.imem_addr, 32'h0);
    // misaligned redirect target traps; PC and instret frozen
    applyStimulus(32'h0050_0093, 0, 0, 0, 1'b1, 32'h42, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    checkOutput("trap.keep_type", 32'(bus.instType), 32'd1);
    checkOutput("trap.keep_imm",  bus.imm, 32'd5);
    checkTrap(32'd11);

    // all-zero word is an illegal opcode
    applyReset();
    applyStimulus(32'h0050_0093, 0, 0, 0, 1'b0, 32'h0, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    retire(1'b0, 32'h0);
    fetchOnly(32'h0000_0000);
    checkTrap(32'd1);

    // valid-looking opcode but low bits not 2'b11
    applyReset();
    fetchOnly(32'h0050_0091);
    checkTrap(32'd0);

    // asynchronous reset while the control word is being offered
    applyReset();
    applyStimulus(32'h0050_0093, 0, 0, 0, 1'b0, 32'h0, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    retire(1'b0, 32'h0);
    waitReq();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    checkOutput("async.valid_before", 32'(bus.ctrl_valid), 32'd1);
    #3 rst = 1'b0;
    #1;
    checkOutput("async.valid_now",   32'(bus.ctrl_valid), 32'd0);
    checkOutput("async.type_now",    32'(bus.instType), 32'd15);
    checkOutput("async.instret_now", bus.instret, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("async.imem_addr", bus.imem_addr, 32'h0);
    checkOutput("async.instret",   bus.instret, 32'd0);
    checkOutput("async.illegal",   32'(bus.illegal), 32'd0);
    checkOutput("async.imem_req",  32'(bus.imem_req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rv32i_fetch_decode.md
Name: rv32i_fetch_decode

Overview:
- Multicycle fetch/decode sequencer on the producer side of the datapath control-word interface.
- Fetches an instruction over a req/ack instruction-memory port and decodes it into the control word: instType, fun3, fun7, rd, rs1, rs2, pc, imm.
- Issues the control word to the datapath with a valid/ready handshake, then waits for completion and redirect information before fetching the next instruction.
- Owns the architectural PC and the retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch byte address; equals the internal PC.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- ctrl_valid  out  1  control word valid.
- ctrl_ready  in  1  datapath accepts the control word.
- instType  out  4  load=0, imm=1, store=2, reg=3, lui=4, auipc=5, brnch=6, jalr=7, jal=8, invalid=15.
- fun3  out  3  instr[14:12].
- fun7  out  1  instr[30].
- rd, rs1, rs2  out  5 each  register indices.
- pc  out  32  address of the issued instruction.
- imm  out  32  sign-extended immediate.
- dp_done  in  1  datapath finished the issued instruction.
- dp_redirect  in  1  branch taken or jump; qualified by dp_done.
- dp_target  in  32  redirect address; qualified by dp_done and dp_redirect.
- illegal  out  1  sticky trap flag.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to FETCH; internal PC = RESET_PC.
  - imem_req=0, ctrl_valid=0, illegal=0, instret=0.
  - All control-word outputs are 0, except instType=15.
  - imem_req rises in the first clock cycle after rst deasserts.
  - Reset asserted in any state aborts the current operation; no partial update survives.
- FETCH:
  - Drive imem_req=1 and imem_addr=PC; both are held stable until imem_ack.
  - On imem_ack: latch imem_rdata, drop imem_req in the next cycle, go to DECODE.
  - imem_ack is ignored in every state other than FETCH.
- DECODE (exactly 1 cycle): register the decoded fields onto the outputs.
  - Opcode mapping: 0000011 load, 0010011 imm, 0100011 store, 0110011 reg, 0110111 lui, 0010111 auipc, 1100011 brnch, 1100111 jalr, 1101111 jal.
  - Any other opcode, or instr[1:0] != 2'b11: go to TRAP.
  - Otherwise go to ISSUE.
- Immediate formats:
  - I-type (load, imm, jalr): sext(instr[31:20]).
  - S-type (store): sext({instr[31:25], instr[11:7]}).
  - B-type (brnch): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (lui, auipc): {instr[31:12], 12'b0}.
  - J-type (jal): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - reg: imm = 0.
- Field zeroing for unused fields:
  - rd = 0 for store and brnch.
  - rs1 = 0 for lui, auipc, jal.
  - rs2 = 0 for every type except store, brnch, reg.
  - fun3 = 0 for lui, auipc, jal.
  - fun7 = instr[30] only for reg, and for imm with fun3=101; otherwise 0.
- ISSUE:
  - ctrl_valid=1; all control-word outputs are held stable while ctrl_valid=1 and ctrl_ready=0.
  - On ctrl_valid && ctrl_ready: go to EXECUTE; ctrl_valid=0 in the next cycle.
  - dp_done is ignored in ISSUE, including when it coincides with ctrl_ready.
- EXECUTE:
  - Wait for dp_done; control-word outputs keep their values.
  - On dp_done with dp_redirect=1 and dp_target[1:0] != 0: go to TRAP (misaligned target); PC and instret are unchanged.
  - On any other dp_done: PC <= dp_redirect ? dp_target : PC+4 (32-bit wrap); instret <= instret+1 (wraps 0xFFFFFFFF→0); go to FETCH.
- TRAP (terminal until reset):
  - illegal=1.
  - imem_req=0, ctrl_valid=0.
  - Control-word outputs keep their last values.
- Timing: with zero-wait handshakes, minimum latency is 4 cycles per instruction (FETCH, DECODE, ISSUE, EXECUTE). ctrl_valid rises 2 cycles after the accepted imem_ack.

Test Plan:
1. Reset release, imem_ack in the first request cycle, rdata 0x00500093 (addi x1,x0,5) -> ctrl_valid two cycles later with instType=1, rd=1, rs1=0, rs2=0, fun3=0, imm=5, pc=0. ctrl_ready=1 then dp_done=1 -> imem_addr=4, instret=1.
2. rdata 0xFE20AE23 (sw x2,-4(x1)) with ctrl_ready held low 3 cycles -> instType=2, rs1=1, rs2=2, rd=0, fun3=2, imm=0xFFFFFFFC; outputs stable across all stall cycles.
3. rdata 0x123452B7 (lui x5,0x12345) -> instType=4, rd=5, rs1=0, fun3=0, imm=0x12345000. Then dp_done=1, dp_redirect=1, dp_target=0x40 -> next imem_addr=0x40.
4. imem_ack delayed 4 cycles -> imem_req and imem_addr constant throughout; imem_ack pulses outside FETCH have no effect.
5. rdata 0x00000000, and separately dp_target=0x42 with dp_redirect=1 -> illegal=1, imem_req stays 0, ctrl_valid stays 0, instret unchanged.
6. rst driven low mid-ISSUE (ctrl_valid=1), asynchronous to clk -> ctrl_valid=0 immediately; after release, imem_addr=RESET_PC, instret=0, illegal=0.
